alu_rr_scheduler: RTL and testbench

Round-robin scheduler that shares one ALU instance among NUM_REQ requesters. Each requester submits an operation (a, b, op) over a valid/ready request channel. The block arbitrates, drives the ALU operand ports from registers, captures the result, and returns it over a per-requester valid/ready response channel. It sits between the requester agents or pipeline stages and the ALU's a/b/op/out interface.

---
 rtl/alu_rr_scheduler.sv | 86 ++++++++
 tb/tb_alu_rr_scheduler.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: round-robin arbiter sharing one ALU (req valid/ready in, alu_a/b/op out, alu_out in, per-requester rsp valid/ready out, busy)
package alu_pkg;
  localparam int OP_WIDTH = 3;
  typedef enum logic [OP_WIDTH-1:0] {OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_PASS} op_t;
endpackage

module alu_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 8,
  localparam int OUT_WIDTH = DATA_WIDTH*2,
  localparam int OP_WIDTH = alu_pkg::OP_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_b,
  input  logic [NUM_REQ*OP_WIDTH-1:0]    req_op,
  output logic [NUM_REQ-1:0]             rsp_valid,
  input  logic [NUM_REQ-1:0]             rsp_ready,
  output logic [OUT_WIDTH-1:0]           rsp_data,
  output logic [DATA_WIDTH-1:0]          alu_a,
  output logic [DATA_WIDTH-1:0]          alu_b,
  output logic [OP_WIDTH-1:0]            alu_op,
  input  logic [OUT_WIDTH-1:0]           alu_out,
  output logic                           busy
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_n;
  logic [IW-1:0] ptr, gnt, win;
  logic [IW:0] s, idx;
  logic found;
  logic [DATA_WIDTH-1:0] a_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] b_arr [NUM_REQ];
  logic [OP_WIDTH-1:0] op_arr [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*DATA_WIDTH +: DATA_WIDTH];
    assign b_arr[i] = req_b[i*DATA_WIDTH +: DATA_WIDTH];
    assign op_arr[i] = req_op[i*OP_WIDTH +: OP_WIDTH];
  end
  always_comb begin
    win = '0;
    found = 1'b0;
    s = '0;
    idx = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      s = {1'b0, ptr} + (IW+1)'(k);
      idx = s >= (IW+1)'(NUM_REQ) ? s - (IW+1)'(NUM_REQ) : s;
      if (req_valid[idx[IW-1:0]]) begin
        win = idx[IW-1:0];
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_n = state;
    req_ready = (state == IDLE && found && !rst) ? NUM_REQ'(1) << win : '0;
    rsp_valid = state == RESP ? NUM_REQ'(1) << gnt : '0;
    busy = state != IDLE;
    state_n = state == IDLE ? (found ? EXEC : IDLE) : state == EXEC ? RESP : (rsp_ready[gnt] ? IDLE : RESP);
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      gnt <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_op <= '0;
      rsp_data <= '0;
    end else begin
      if (state == IDLE && found) begin
        gnt <= win;
        alu_a <= a_arr[win];
        alu_b <= b_arr[win];
        alu_op <= op_arr[win];
      end
      if (state == EXEC) rsp_data <= alu_out;
      if (state == RESP && rsp_ready[gnt]) ptr <= gnt == IW'(NUM_REQ-1) ? '0 : gnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb_alu_rr_scheduler: directed self-checking bench for alu_rr_scheduler with a behavioural ALU
module tb_alu_rr_scheduler;
  import alu_pkg::*;
  localparam int N = 4, DW = 8, OW = 16, OPW = alu_pkg::OP_WIDTH;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*DW-1:0] req_a, req_b;
  logic [N*OPW-1:0] req_op;
  logic [OW-1:0] rsp_data, alu_out;
  logic [DW-1:0] alu_a, alu_b;
  logic [OPW-1:0] alu_op;
  logic busy;
  int checks = 0, errors = 0;
  logic [15:0] exp2 [4] = '{16'h0011, 16'h0040, 16'h01E0, 16'h00FF};
  int ord [5] = '{0, 1, 2, 3, 0};
  always #5 clk = ~clk;
  always_comb begin
    alu_out = '0;
    case (alu_op)
      OP_ADD:  alu_out = OW'(alu_a) + OW'(alu_b);
      OP_SUB:  alu_out = OW'(alu_a) - OW'(alu_b);
      OP_MUL:  alu_out = OW'(alu_a) * OW'(alu_b);
      OP_AND:  alu_out = OW'(alu_a & alu_b);
      OP_OR:   alu_out = OW'(alu_a | alu_b);
      OP_XOR:  alu_out = OW'(alu_a ^ alu_b);
      OP_SHL:  alu_out = OW'(alu_a) << alu_b[3:0];
      default: alu_out = OW'(alu_a);
    endcase
  end
  alu_rr_scheduler #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .req_op(req_op), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .alu_a(alu_a),
    .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out), .busy(busy)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [OPW-1:0] op);
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
    req_op[i*OPW +: OPW] = op;
  endtask
  initial begin
    rst = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 4'b1111;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    tick;
    tick;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_rsp_data", rsp_data, 0);
    rst = 1'b0;
    req_valid = 4'b0001;
    set_req(0, 8'hFF, 8'h02, OP_MUL);
    #1;
    chk("single_ready", req_ready, 4'b0001);
    tick;
    req_valid = 4'b0000;
    #1;
    chk("single_alu_a", alu_a, 8'hFF);
    chk("single_alu_b", alu_b, 8'h02);
    chk("single_alu_op", alu_op, OP_MUL);
    chk("single_exec_busy", busy, 1);
    chk("single_exec_rsp_valid", rsp_valid, 0);
    chk("single_exec_ready", req_ready, 0);
    tick;
    chk("single_rsp_valid", rsp_valid, 4'b0001);
    chk("single_rsp_data", rsp_data, 16'h01FE);
    tick;
    chk("single_done_busy", busy, 0);
    chk("single_done_rsp_valid", rsp_valid, 0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    set_req(0, 8'h10, 8'h01, OP_ADD);
    set_req(1, 8'h20, 8'h02, OP_MUL);
    set_req(2, 8'hF0, 8'hF0, OP_ADD);
    set_req(3, 8'h0F, 8'hF0, OP_XOR);
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("rr_ready", req_ready, 1 << ord[k]);
      tick;
      chk("rr_exec_busy", busy, 1);
      chk("rr_exec_rsp_valid", rsp_valid, 0);
      chk("rr_exec_ready", req_ready, 0);
      tick;
      chk("rr_rsp_valid", rsp_valid, 1 << ord[k]);
      chk("rr_rsp_data", rsp_data, exp2[ord[k]]);
      tick;
    end
    req_valid = 4'b0100;
    rsp_ready = 4'b0000;
    #1;
    chk("bp_ready", req_ready, 4'b0100);
    tick;
    req_valid = 4'b1011;
    rsp_ready = 4'b1011;
    #1;
    chk("bp_exec_ready", req_ready, 0);
    tick;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", rsp_valid, 4'b0100);
      chk("bp_rsp_data", rsp_data, 16'h01E0);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_busy", busy, 1);
      tick;
    end
    rsp_ready = 4'b0100;
    req_valid = 4'b1001;
    #1;
    chk("bp_release_rsp_valid", rsp_valid, 4'b0100);
    chk("bp_release_ready", req_ready, 0);
    tick;
    chk("bp_done_busy", busy, 0);
    chk("bp_done_rsp_valid", rsp_valid, 0);
    chk("wrap_first_ready", req_ready, 4'b1000);
    rsp_ready = 4'b1111;
    tick;
    tick;
    chk("wrap_first_rsp_valid", rsp_valid, 4'b1000);
    chk("wrap_first_rsp_data", rsp_data, 16'h00FF);
    tick;
    chk("wrap_second_ready", req_ready, 4'b0001);
    tick;
    tick;
    chk("wrap_second_rsp_valid", rsp_valid, 4'b0001);
    chk("wrap_second_rsp_data", rsp_data, 16'h0011);
    tick;
    req_valid = 4'b1111;
    #1;
    chk("wrap_ptr1_ready", req_ready, 4'b0010);
    req_valid = 4'b0000;
    #1;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("idle_ready", req_ready, 0);
      chk("idle_rsp_valid", rsp_valid, 0);
      chk("idle_busy", busy, 0);
      chk("idle_alu_a", alu_a, 8'h10);
      chk("idle_alu_b", alu_b, 8'h01);
      chk("idle_alu_op", alu_op, OP_ADD);
    end
    req_valid = 4'b0010;
    #1;
    chk("r1_ready", req_ready, 4'b0010);
    tick;
    req_valid = 4'b0000;
    chk("r1_alu_a", alu_a, 8'h20);
    chk("r1_alu_b", alu_b, 8'h02);
    chk("r1_alu_op", alu_op, OP_MUL);
    tick;
    chk("r1_rsp_valid", rsp_valid, 4'b0010);
    chk("r1_rsp_data", rsp_data, 16'h0040);
    tick;
    req_valid = 4'b1000;
    #1;
    chk("rx_ready", req_ready, 4'b1000);
    tick;
    req_valid = 4'b0000;
    rst = 1'b1;
    #1;
    chk("rx_exec_busy", busy, 1);
    chk("rx_exec_ready", req_ready, 0);
    tick;
    rst = 1'b0;
    #1;
    chk("rx_busy", busy, 0);
    chk("rx_rsp_valid", rsp_valid, 0);
    chk("rx_alu_a", alu_a, 0);
    chk("rx_alu_b", alu_b, 0);
    chk("rx_alu_op", alu_op, 0);
    chk("rx_rsp_data", rsp_data, 0);
    tick;
    chk("rx_idle_rsp_valid", rsp_valid, 0);
    req_valid = 4'b1010;
    #1;
    chk("rx_ptr0_ready", req_ready, 4'b0010);
    tick;
    req_valid = 4'b0000;
    chk("rx_next_exec_rsp_valid", rsp_valid, 0);
    tick;
    chk("rx_next_rsp_valid", rsp_valid, 4'b0010);
    chk("rx_next_rsp_data", rsp_data, 16'h0040);
    tick;
    chk("rx_next_done_busy", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
